// File: rtl/pyramid_pkg.sv
// Shared constants and types for the 4/5 image pyramid: scale ratio, level count,
// upscaler FSM states and the default coordinate type.
package pyramid_pkg;

    // round(c * 5 / 4) == (c * SCALE_NUM + SCALE_ROUND) >> SCALE_SHIFT
    localparam int SCALE_NUM   = 5;
    localparam int SCALE_SHIFT = 2;
    localparam int SCALE_ROUND = 2;

    localparam int DEFAULT_NUM_LEVELS = 8;
    localparam int DEFAULT_COORD_BITS = 16;

    typedef logic [DEFAULT_COORD_BITS-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCALE = 2'd1,
        DONE  = 2'd2
    } upscaler_state_t;

endpackage : pyramid_pkg

// File: rtl/coord_scale_step_5_4.sv
// One level of 4/5-pyramid upscaling on a single axis: round(c*5/4), saturating.
// Purely combinational.
module coord_scale_step_5_4
    import pyramid_pkg::*;
#(
    parameter int COORD_BITS = 16
) (
    input  logic [COORD_BITS-1:0] c,
    output logic [COORD_BITS-1:0] result,
    output logic                  sat
);

    // Three guard bits hold c*5+2 without overflow for any COORD_BITS-wide c.
    localparam int W = COORD_BITS + 3;

    logic [W-1:0] c_ext;
    logic [W-1:0] prod;
    logic [W-1:0] s;

    always_comb begin
        c_ext  = {3'b000, c};
        prod   = c_ext * W'(SCALE_NUM) + W'(SCALE_ROUND);
        s      = prod >> SCALE_SHIFT;
        sat    = |s[W-1:COORD_BITS];
        result = sat ? {COORD_BITS{1'b1}} : s[COORD_BITS-1:0];
    end

endmodule : coord_scale_step_5_4

// File: rtl/coordinate_upscaler_5_4.sv
// Maps a level-L feature coordinate to level 0 by applying round(c*5/4) L times, one level
// per clock; result valid L+1 clocks after accept, held in DONE until out_ready.
module coordinate_upscaler_5_4
    import pyramid_pkg::*;
#(
    parameter int COORD_BITS = 16,
    parameter int LEVEL_BITS = 3,
    parameter int NUM_LEVELS = DEFAULT_NUM_LEVELS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [COORD_BITS-1:0] in_x,
    input  logic [COORD_BITS-1:0] in_y,
    input  logic [LEVEL_BITS-1:0] in_level,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [COORD_BITS-1:0] out_x,
    output logic [COORD_BITS-1:0] out_y,
    output logic                  out_sat
);

    upscaler_state_t       state_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic [COORD_BITS-1:0] x_q;
    logic [COORD_BITS-1:0] y_q;
    logic                  sat_q;
    logic [LEVEL_BITS-1:0] remaining_q;

    logic [COORD_BITS-1:0] x_d;
    logic [COORD_BITS-1:0] y_d;
    logic                  sat_x;
    logic                  sat_y;
    logic [LEVEL_BITS-1:0] level_clamped;

    coord_scale_step_5_4 #(.COORD_BITS(COORD_BITS)) u_step_x (
        .c      (x_q),
        .result (x_d),
        .sat    (sat_x)
    );

    coord_scale_step_5_4 #(.COORD_BITS(COORD_BITS)) u_step_y (
        .c      (y_q),
        .result (y_d),
        .sat    (sat_y)
    );

    // Out-of-range levels behave as the coarsest legal level.
    always_comb begin
        level_clamped = in_level;
        if (int'(in_level) > NUM_LEVELS - 1) begin
            level_clamped = LEVEL_BITS'(NUM_LEVELS - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            sat_q       <= 1'b0;
            remaining_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x_q         <= in_x;
                        y_q         <= in_y;
                        sat_q       <= 1'b0;
                        remaining_q <= level_clamped;
                        in_ready_q  <= 1'b0;
                        if (level_clamped == '0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= SCALE;
                        end
                    end
                end
                SCALE: begin
                    x_q         <= x_d;
                    y_q         <= y_d;
                    sat_q       <= sat_q | sat_x | sat_y;
                    remaining_q <= remaining_q - LEVEL_BITS'(1);
                    if (remaining_q == LEVEL_BITS'(1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    // in_ready rises only after the handshake edge, never alongside it.
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_x     = x_q;
    assign out_y     = y_q;
    assign out_sat   = sat_q;

endmodule : coordinate_upscaler_5_4

// File: tb/tb_coordinate_upscaler_5_4.sv
// Directed bench for coordinate_upscaler_5_4: hand-computed vectors, stall, mid-run reset
// and a level-1 sweep against (c*5+2)>>2.
module tb_coordinate_upscaler_5_4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [15:0] in_y;
    logic [2:0]  in_level;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_x;
    logic [15:0] out_y;
    logic        out_sat;

    int checks   = 0;
    int failures = 0;

    coordinate_upscaler_5_4 #(.COORD_BITS(16), .LEVEL_BITS(3), .NUM_LEVELS(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_level  (in_level),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for exactly one edge; caller is #1 after a posedge.
    task automatic accept(input logic [15:0] x, input logic [15:0] y, input logic [2:0] lvl);
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_x     = x;
        in_y     = y;
        in_level = lvl;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_after_hs"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_after_hs"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_txn(input string tag, input logic [15:0] x, input logic [15:0] y,
                           input logic [2:0] lvl, input logic [15:0] ex, input logic [15:0] ey,
                           input logic es);
        int lat;
        accept(x, y, lvl);
        wait_done(lat);
        check({tag, "_latency"}, 32'(lat), 32'(lvl) + 32'd1);
        check({tag, "_x"}, 32'(out_x), 32'(ex));
        check({tag, "_y"}, 32'(out_y), 32'(ey));
        check({tag, "_sat"}, 32'(out_sat), 32'(es));
        check({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
        release_result(tag);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int exp_x;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_level  = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        check("rst_state_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_x", 32'(out_x), 32'd0);
        check("rst_out_y", 32'(out_y), 32'd0);
        check("rst_out_sat", 32'(out_sat), 32'd0);
        reset = 1'b0;
        tick();

        run_txn("t1_l1", 16'd4, 16'd3, 3'd1, 16'd5, 16'd4, 1'b0);
        run_txn("t2_l2", 16'd100, 16'd0, 3'd2, 16'd156, 16'd0, 1'b0);
        run_txn("t3_l0", 16'd7, 16'd9, 3'd0, 16'd7, 16'd9, 1'b0);
        run_txn("t3_l7", 16'd1, 16'd0, 3'd7, 16'd1, 16'd0, 1'b0);
        run_txn("t3_l3", 16'd1000, 16'd3, 3'd3, 16'd1954, 16'd6, 1'b0);
        run_txn("t4_sat", 16'd60000, 16'd0, 3'd1, 16'd65535, 16'd0, 1'b1);
        run_txn("t4_clear", 16'd8, 16'd0, 3'd1, 16'd10, 16'd0, 1'b0);
        run_txn("t4_ysat", 16'd4, 16'd65535, 3'd2, 16'd6, 16'd65535, 1'b1);

        // Stall in DONE while a competing request is presented.
        accept(16'd40, 16'd2, 3'd1);
        wait_done(lat);
        check("t5_latency", 32'(lat), 32'd2);
        in_x     = 16'd999;
        in_y     = 16'd999;
        in_level = 3'd3;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t5_stall_valid", 32'(out_valid), 32'd1);
            check("t5_stall_x", 32'(out_x), 32'd50);
            check("t5_stall_y", 32'(out_y), 32'd3);
            check("t5_stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        release_result("t5");
        tick();
        check("t5_idle_keeps_x", 32'(out_x), 32'd50);
        check("t5_idle_no_valid", 32'(out_valid), 32'd0);

        // Reset in the middle of a level-5 SCALE sequence.
        accept(16'd100, 16'd100, 3'd5);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_sat", 32'(out_sat), 32'd0);
        check("t6_rst_x", 32'(out_x), 32'd0);
        check("t6_rst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t6_no_stale_valid", 32'(out_valid), 32'd0);
        end
        run_txn("t6_after", 16'd100, 16'd0, 3'd2, 16'd156, 16'd0, 1'b0);

        for (int c = 1; c <= 2000; c++) begin
            exp_x = (c * 5 + 2) >> 2;
            run_txn("sweep", 16'(c), 16'(2001 - c), 3'd1, 16'(exp_x),
                    16'((((2001 - c) * 5) + 2) >> 2), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_coordinate_upscaler_5_4

// File: doc/coordinate_upscaler_5_4.md
Name: coordinate_upscaler_5_4

Overview:
Maps a feature coordinate found at pyramid level L back to base-level (level 0) image coordinates. It inverts the 4/5 per-level dimension downscaling by applying round(c*5/4) once per level, L times, to both axes. It sits between the per-level feature detectors and the feature output stage. Multicycle: one level per clock, with a valid/ready handshake on both sides.

Parameters:
COORD_BITS, 16, width of x/y coordinates at every level.
LEVEL_BITS, 3, width of the level field.
NUM_LEVELS, 8, number of pyramid levels; legal levels are 0..NUM_LEVELS-1.

Ports:
clk  input  1  clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  request present.
in_ready  output  1  block can accept; high only in IDLE.
in_x  input  COORD_BITS  x coordinate at level in_level.
in_y  input  COORD_BITS  y coordinate at level in_level.
in_level  input  LEVEL_BITS  source pyramid level.
out_valid  output  1  result present; high only in DONE.
out_ready  input  1  consumer accepts the result.
out_x  output  COORD_BITS  base-level x.
out_y  output  COORD_BITS  base-level y.
out_sat  output  1  at least one step saturated on either axis for this result.

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, out_x=0, out_y=0, out_sat=0, remaining=0. Reset overrides everything, including a transaction mid-SCALE or mid-DONE. The transaction is discarded and no out_valid pulse occurs.
- States: IDLE, SCALE, DONE.
- Step function, applied per axis: s = (c*5 + 2) >> 2, computed in COORD_BITS+3 bits. If s > 2^COORD_BITS-1, the result is 2^COORD_BITS-1 and the step's sat flag is 1. Otherwise the result is s[COORD_BITS-1:0] and sat is 0.
- Level clamp: levels at or above NUM_LEVELS are treated as NUM_LEVELS-1.
- IDLE, when in_valid && in_ready:
  - Register x=in_x, y=in_y, remaining=clamped level, and clear out_sat.
  - Next state is DONE if the level is 0, else SCALE.
- SCALE, each cycle:
  - x=step(x), y=step(y).
  - out_sat |= sat_x | sat_y.
  - remaining--.
  - When remaining is 1 before the decrement, go to DONE.
- DONE: out_valid=1, and out_x/out_y/out_sat hold stable.
  - When out_ready=1, go to IDLE.
  - out_ready low stalls indefinitely with outputs held.
- Latency: out_valid first high L+1 clocks after the accepting edge (level 0 gives 1 clock).
- Throughput: one transaction per L+2 clocks, because in_ready stays low during SCALE and DONE. A new request is not accepted in the same cycle the result handshake completes.
- No pipelining; in_valid with in_ready low has no effect. Inputs are sampled only at the accepting edge.
- Zero is a fixed point: step(0)=0.
- out_x/out_y retain their last values in IDLE (not cleared).

Decomposition:
- pyramid_pkg holds:
  - SCALE_NUM=5, SCALE_SHIFT=2, SCALE_ROUND=2.
  - NUM_LEVELS default constant.
  - typedef enum upscaler_state_t {IDLE, SCALE, DONE}.
  - coord_t typedef sized by COORD_BITS.
  - This package is shared with the existing 4/5 dimension calculator.
- Sub-module coord_scale_step_5_4: combinational, parameter COORD_BITS, in c, outputs result and sat. It is instantiated twice (x, y) and is unit-testable on its own.

Test Plan:
1. Reset, then in_x=4, in_y=3, level=1 -> after 2 clocks out_valid=1, out_x=5, out_y=4, out_sat=0; in_ready low until the out_ready handshake.
2. in_x=100, in_y=0, level=2 -> 125 then 156; out_x=156, out_y=0, out_valid 3 clocks after accept.
3. Level 0, in_x=7, in_y=9 -> out_x=7, out_y=9 one clock after accept; level=7 with x=1 -> chain 1,1,1,... gives out_x=1.
4. COORD_BITS=16, in_x=60000, level=1 -> out_x=65535, out_sat=1. Follow-up request x=8, level=1 -> out_x=10, out_sat=0, proving sat is cleared per transaction.
5. Hold out_ready=0 for 10 clocks in DONE -> out_valid and outputs stable and in_valid ignored; out_ready=1 -> IDLE next clock, in_ready=1.
6. Assert reset during SCALE of a level-5 request -> next clock IDLE, out_valid=0, out_sat=0, out_x=0; the next request completes correctly. Also sweep in_x over 1..2000 at level 1 against the golden model (c*5+2)>>2.
